// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access controller:
//   - FSM state encoding (IDLE, WAIT, ACCESS, DONE)
//   - operation-type encoding (read / write)
//   - default width constants and the wait-counter width
// ---------------------------------------------------------------------------
package dm_pkg;

   localparam int DM_REG_W  = 12;  // default data word width
   localparam int DM_ADDR_W = 8;   // default address width
   localparam int DM_WCNT_W = 4;   // wait counter covers 0..15

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } dm_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } dm_op_e;

endpackage

// File: rtl/dm_ram.sv
// ---------------------------------------------------------------------------
// dm_ram
// Single-port synchronous array, 2**aw words of dw bits, with a registered
// read port. The array itself has no reset so its contents survive a reset;
// only the read register is cleared.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  async active-low reset (read register only)
//   we     in  write enable
//   re     in  read enable; rdata updates on the edge where re=1
//   addr   in  word address
//   wdata  in  write word
//   rdata  out registered read word, holds between reads
// ---------------------------------------------------------------------------
module dm_ram #(
   parameter int dw = 12,
   parameter int aw = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [aw-1:0] addr,
   input  logic [dw-1:0] wdata,
   output logic [dw-1:0] rdata
);

   logic [dw-1:0] mem [2**aw];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl
// Data-memory access controller for the 12-bit datapath. Accepts one read or
// write at a time from IDLE, inserts wait_states wait cycles, performs the
// array access, then pulses done (and dr_load on reads) for one cycle.
// Optional macro DM_PARITY_EN adds an even-parity bit per word; a read whose
// stored parity mismatches pulses parity_err together with done.
// Ports:
//   clk         in  rising-edge clock
//   reset       in  async active-low reset
//   rd_req      in  read request (sampled in IDLE only)
//   wr_req      in  write request (sampled in IDLE only, wins over rd_req)
//   addr        in  word address, latched on acceptance
//   wr_data     in  write word from DR dataout, latched on acceptance
//   busy        out high in every state except IDLE
//   done        out one-cycle completion pulse
//   rd_data     out last word read, to DR DM_datain
//   dr_load     out one-cycle pulse on read completion, to DR writeEn_frDM
//   parity_err  out one-cycle pulse with done on a parity mismatch
// ---------------------------------------------------------------------------
module dm_access_ctrl
   import dm_pkg::*;
#(
   parameter int reg_width   = DM_REG_W,
   parameter int addr_width  = DM_ADDR_W,
   parameter int wait_states = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_req,
   input  logic                  wr_req,
   input  logic [addr_width-1:0] addr,
   input  logic [reg_width-1:0]  wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [reg_width-1:0]  rd_data,
   output logic                  dr_load,
   output logic                  parity_err
);

`ifdef DM_PARITY_EN
   localparam int MW = reg_width + 1;
`else
   localparam int MW = reg_width;
`endif

   // Counter start value; with zero wait states WAIT is skipped entirely.
   localparam logic [DM_WCNT_W-1:0] WS_LOAD =
      (wait_states > 0) ? DM_WCNT_W'(wait_states - 1) : '0;

   dm_state_e             state, state_nxt;
   dm_op_e                op_q;
   logic [addr_width-1:0] addr_q;
   logic [reg_width-1:0]  wdata_q;
   logic [DM_WCNT_W-1:0]  wcnt;
   logic                  accept;

   logic                  ram_we, ram_re;
   logic [MW-1:0]         ram_wdata, ram_rdata;

   assign accept = (state == IDLE) && (wr_req || rd_req);

   // State register, request latches and wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         wcnt    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= wr_req ? OP_WR : OP_RD;
            addr_q  <= addr;
            wdata_q <= wr_data;
            wcnt    <= WS_LOAD;
         end else if (state == WAIT && wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = (wait_states > 0) ? WAIT : ACCESS;
         WAIT:    if (wcnt == '0) state_nxt = ACCESS;
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The array is touched only in ACCESS; the registered read lands on the
   // ACCESS->DONE edge so rd_data is valid in the DONE cycle.
   assign ram_we = (state == ACCESS) && (op_q == OP_WR);
   assign ram_re = (state == ACCESS) && (op_q == OP_RD);

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign dr_load = (state == DONE) && (op_q == OP_RD);

`ifdef DM_PARITY_EN
   // Even parity: stored bit makes the XOR over the full word zero.
   assign ram_wdata  = {^wdata_q, wdata_q};
   assign rd_data    = ram_rdata[reg_width-1:0];
   assign parity_err = dr_load && (^ram_rdata);
`else
   assign ram_wdata  = wdata_q;
   assign rd_data    = ram_rdata;
   assign parity_err = 1'b0;
`endif

   dm_ram #(
      .dw (MW),
      .aw (addr_width)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr_q),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
